// File: rtl/nearcmp_multi.sv
// nearcmp_multi: nearest-hit tracker for NRAYS independent ray slots.
// Each slot is a small EMPTY/HELD FSM holding the closest accepted hit
// (t, u, v, triid). Readout of slot rd_ray is registered with one cycle of
// latency and reads the slot before any same-cycle update.
// Optional feature: define NEARCMP_HITCNT_EN to add an 8-bit saturating
// per-slot accept counter, exposed on hit_cnt.
module nearcmp_multi #(
  parameter int T_W        = 32,
  parameter int UV_W       = 16,
  parameter int ID_W       = 16,
  parameter int NRAYS      = 4,
  parameter int TIE_LATEST = 0
) (
  input  logic                     clk,
  input  logic                     globalreset,
  input  logic                     in_valid,
  input  logic [$clog2(NRAYS)-1:0] in_ray,
  input  logic                     hit,
  input  logic [T_W-1:0]           tin,
  input  logic [UV_W-1:0]          uin,
  input  logic [UV_W-1:0]          vin,
  input  logic [ID_W-1:0]          triidin,
  input  logic                     clr,
  input  logic [$clog2(NRAYS)-1:0] rd_ray,
  output logic [T_W-1:0]           t,
  output logic [UV_W-1:0]          u,
  output logic [UV_W-1:0]          v,
  output logic [ID_W-1:0]          triid,
  output logic                     anyhit,
`ifdef NEARCMP_HITCNT_EN
  output logic [7:0]               hit_cnt,
`endif
  output logic [NRAYS-1:0]         held_mask
);

  localparam int RW = $clog2(NRAYS);

  typedef enum logic {
    EMPTY = 1'b0,
    HELD  = 1'b1
  } slot_state_e;

  slot_state_e     state_r   [NRAYS];
  slot_state_e     state_nxt [NRAYS];
  logic            acc       [NRAYS];
  logic            ld        [NRAYS];
  logic [T_W-1:0]  t_r       [NRAYS];
  logic [UV_W-1:0] u_r       [NRAYS];
  logic [UV_W-1:0] v_r       [NRAYS];
  logic [ID_W-1:0] id_r      [NRAYS];

  // Decode which slot (if any) the current beat is a real hit for.
  always_comb begin
    for (int i = 0; i < NRAYS; i++) begin
      acc[i] = in_valid & hit & (in_ray == RW'(i));
    end
  end

  // Next-state and latch-enable decision for every slot.
  always_comb begin
    for (int i = 0; i < NRAYS; i++) begin
      state_nxt[i] = state_r[i];
      ld[i]        = 1'b0;
      case (state_r[i])
        EMPTY: begin
          if (acc[i]) begin
            state_nxt[i] = HELD;
            ld[i]        = 1'b1;
          end else begin
            state_nxt[i] = EMPTY;
          end
        end
        HELD: begin
          if (clr && (in_ray == RW'(i))) begin
            // New ray: any candidate wins; without one the slot empties.
            if (acc[i]) begin
              state_nxt[i] = HELD;
              ld[i]        = 1'b1;
            end else begin
              state_nxt[i] = EMPTY;
            end
          end else if (acc[i]) begin
            state_nxt[i] = HELD;
            if (tin < t_r[i]) begin
              ld[i] = 1'b1;
            end else if ((tin == t_r[i]) && (TIE_LATEST != 0)) begin
              ld[i] = 1'b1;
            end else begin
              ld[i] = 1'b0;
            end
          end else begin
            state_nxt[i] = HELD;
          end
        end
        default: begin
          state_nxt[i] = EMPTY;
          ld[i]        = 1'b0;
        end
      endcase
    end
  end

  // Slot state register.
  always_ff @(posedge clk or posedge globalreset) begin
    if (globalreset) begin
      for (int i = 0; i < NRAYS; i++) begin
        state_r[i] <= EMPTY;
      end
    end else begin
      for (int i = 0; i < NRAYS; i++) begin
        state_r[i] <= state_nxt[i];
      end
    end
  end

  // Held-mask output taken straight from the state flops.
  always_comb begin
    for (int i = 0; i < NRAYS; i++) begin
      held_mask[i] = (state_r[i] == HELD);
    end
  end

  // Stored hit fields; all four update together when the slot latches.
  always_ff @(posedge clk or posedge globalreset) begin
    if (globalreset) begin
      for (int i = 0; i < NRAYS; i++) begin
        t_r[i]  <= {T_W{1'b0}};
        u_r[i]  <= {UV_W{1'b0}};
        v_r[i]  <= {UV_W{1'b0}};
        id_r[i] <= {ID_W{1'b0}};
      end
    end else begin
      for (int i = 0; i < NRAYS; i++) begin
        if (ld[i]) begin
          t_r[i]  <= tin;
          u_r[i]  <= uin;
          v_r[i]  <= vin;
          id_r[i] <= triidin;
        end
      end
    end
  end

  // Registered readout of slot rd_ray (pre-update values).
  always_ff @(posedge clk or posedge globalreset) begin
    if (globalreset) begin
      t      <= {T_W{1'b0}};
      u      <= {UV_W{1'b0}};
      v      <= {UV_W{1'b0}};
      triid  <= {ID_W{1'b0}};
      anyhit <= 1'b0;
    end else begin
      t      <= t_r[rd_ray];
      u      <= u_r[rd_ray];
      v      <= v_r[rd_ray];
      triid  <= id_r[rd_ray];
      anyhit <= (state_r[rd_ray] == HELD);
    end
  end

`ifdef NEARCMP_HITCNT_EN
  logic [7:0] cnt_r   [NRAYS];
  logic [7:0] cnt_nxt [NRAYS];

  // Saturating accept counter; clr restarts it (at 1 if the clr beat accepts).
  always_comb begin
    for (int i = 0; i < NRAYS; i++) begin
      cnt_nxt[i] = cnt_r[i];
      if (clr && (in_ray == RW'(i))) begin
        cnt_nxt[i] = acc[i] ? 8'd1 : 8'd0;
      end else if (acc[i] && (cnt_r[i] != 8'd255)) begin
        cnt_nxt[i] = cnt_r[i] + 8'd1;
      end else begin
        cnt_nxt[i] = cnt_r[i];
      end
    end
  end

  // Counter storage and its registered readout.
  always_ff @(posedge clk or posedge globalreset) begin
    if (globalreset) begin
      for (int i = 0; i < NRAYS; i++) begin
        cnt_r[i] <= 8'd0;
      end
      hit_cnt <= 8'd0;
    end else begin
      for (int i = 0; i < NRAYS; i++) begin
        cnt_r[i] <= cnt_nxt[i];
      end
      hit_cnt <= cnt_r[rd_ray];
    end
  end
`endif

endmodule

// File: tb/tb_nearcmp_multi.sv
// Self-checking bench for nearcmp_multi: a behavioural slot model feeds a
// scoreboard queue of expected readouts, compared one edge later, plus
// directed scenario checks with fixed expected values.
module tb_nearcmp_multi;
  localparam int T_W = 32, UV_W = 16, ID_W = 16, NRAYS = 4, RW = 2, TIE = 0;

  logic clk = 1'b0;
  logic globalreset, in_valid, hit, clr;
  logic [RW-1:0] in_ray, rd_ray;
  logic [T_W-1:0] tin, t;
  logic [UV_W-1:0] uin, vin, u, v;
  logic [ID_W-1:0] triidin, triid;
  logic anyhit;
  logic [NRAYS-1:0] held_mask;
`ifdef NEARCMP_HITCNT_EN
  logic [7:0] hit_cnt;
`endif

  nearcmp_multi #(.T_W(T_W), .UV_W(UV_W), .ID_W(ID_W), .NRAYS(NRAYS), .TIE_LATEST(TIE)) dut (
    .clk(clk), .globalreset(globalreset), .in_valid(in_valid), .in_ray(in_ray),
    .hit(hit), .tin(tin), .uin(uin), .vin(vin), .triidin(triidin), .clr(clr),
    .rd_ray(rd_ray), .t(t), .u(u), .v(v), .triid(triid), .anyhit(anyhit),
`ifdef NEARCMP_HITCNT_EN
    .hit_cnt(hit_cnt),
`endif
    .held_mask(held_mask)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [T_W-1:0]  t;
    logic [UV_W-1:0] u;
    logic [UV_W-1:0] v;
    logic [ID_W-1:0] id;
    logic            any;
    logic [7:0]      cnt;
  } rd_t;

  rd_t q[$];
  logic            m_held [NRAYS];
  logic [T_W-1:0]  m_t    [NRAYS];
  logic [UV_W-1:0] m_u    [NRAYS];
  logic [UV_W-1:0] m_v    [NRAYS];
  logic [ID_W-1:0] m_id   [NRAYS];
  logic [7:0]      m_cnt  [NRAYS];
  int checks = 0;
  int errors = 0;

  task automatic model_reset();
    for (int i = 0; i < NRAYS; i++) begin
      m_held[i] = 1'b0; m_t[i] = '0; m_u[i] = '0; m_v[i] = '0; m_id[i] = '0; m_cnt[i] = 8'd0;
    end
    q.delete();
  endtask

  task automatic drive(input logic iv, input logic ih, input logic ic, input logic [RW-1:0] r,
                       input logic [RW-1:0] rd, input logic [T_W-1:0] tt,
                       input logic [UV_W-1:0] uu, input logic [UV_W-1:0] vv,
                       input logic [ID_W-1:0] id);
    in_valid = iv; hit = ih; clr = ic; in_ray = r; rd_ray = rd;
    tin = tt; uin = uu; vin = vv; triidin = id;
  endtask

  task automatic idle(input logic [RW-1:0] rd);
    drive(1'b0, 1'b0, 1'b0, 2'd0, rd, 32'd0, 16'd0, 16'd0, 16'd0);
  endtask

  // One clock: queue expected readout, advance model, compare outputs.
  task automatic step();
    rd_t e, a;
    logic acc, lat;
    logic [NRAYS-1:0] mm;
    int s;
    e.t = m_t[rd_ray]; e.u = m_u[rd_ray]; e.v = m_v[rd_ray]; e.id = m_id[rd_ray];
    e.any = m_held[rd_ray]; e.cnt = m_cnt[rd_ray];
    q.push_back(e);
    @(posedge clk);
    s   = int'(in_ray);
    acc = in_valid && hit;
    lat = 1'b0;
    if (!m_held[s]) begin
      lat = acc;
    end else if (clr) begin
      if (acc) lat = 1'b1;
      else m_held[s] = 1'b0;
    end else if (acc && ((tin < m_t[s]) || ((TIE != 0) && (tin == m_t[s])))) begin
      lat = 1'b1;
    end
    if (lat) begin
      m_held[s] = 1'b1; m_t[s] = tin; m_u[s] = uin; m_v[s] = vin; m_id[s] = triidin;
    end
    if (clr) m_cnt[s] = acc ? 8'd1 : 8'd0;
    else if (acc && (m_cnt[s] != 8'd255)) m_cnt[s] = m_cnt[s] + 8'd1;
    #1;
    e = q.pop_front();
    a.t = t; a.u = u; a.v = v; a.id = triid; a.any = anyhit; a.cnt = 8'd0;
`ifdef NEARCMP_HITCNT_EN
    a.cnt = hit_cnt;
`else
    e.cnt = 8'd0;
`endif
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL readout: got t=%0d u=%0d v=%0d id=%0d any=%0b cnt=%0d, want t=%0d u=%0d v=%0d id=%0d any=%0b cnt=%0d",
               a.t, a.u, a.v, a.id, a.any, a.cnt, e.t, e.u, e.v, e.id, e.any, e.cnt);
    end
    for (int i = 0; i < NRAYS; i++) mm[i] = m_held[i];
    checks++;
    if (held_mask !== mm) begin
      errors++;
      $display("FAIL held_mask: got %b want %b", held_mask, mm);
    end
  endtask

  task automatic chk(input string name, input logic [T_W-1:0] got, input logic [T_W-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic test_reset();
    globalreset = 1'b1;
    idle(2'd0);
    #1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({t, u, v, triid, anyhit, held_mask} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got t=%0d id=%0d any=%0b mask=%b want all 0", t, triid, anyhit, held_mask);
    end
    globalreset = 1'b0;
    model_reset();
  endtask

  task automatic test_first_accept();
    drive(1'b1, 1'b1, 1'b0, 2'd2, 2'd2, 32'd100, 16'd5, 16'd6, 16'd7);
    step();
    idle(2'd2);
    step();
    chk("first_t", t, 32'd100);
    chk("first_u", {16'd0, u}, 32'd5);
    chk("first_v", {16'd0, v}, 32'd6);
    chk("first_id", {16'd0, triid}, 32'd7);
    chk("first_any", {31'd0, anyhit}, 32'd1);
    chk("first_mask", {28'd0, held_mask}, 32'd4);
  endtask

  task automatic test_nearer();
    drive(1'b1, 1'b1, 1'b0, 2'd2, 2'd2, 32'd50, 16'd1, 16'd1, 16'd9);
    step(); idle(2'd2); step();
    chk("nearer_id", {16'd0, triid}, 32'd9);
    drive(1'b1, 1'b1, 1'b0, 2'd2, 2'd2, 32'd80, 16'd2, 16'd2, 16'd3);
    step(); idle(2'd2); step();
    chk("farther_t", t, 32'd50);
    chk("farther_id", {16'd0, triid}, 32'd9);
  endtask

  task automatic test_tie();
    drive(1'b1, 1'b1, 1'b0, 2'd1, 2'd1, 32'd40, 16'd0, 16'd0, 16'd1);
    step();
    drive(1'b1, 1'b1, 1'b0, 2'd1, 2'd1, 32'd40, 16'd0, 16'd0, 16'd2);
    step(); idle(2'd1); step();
    chk("tie_id", {16'd0, triid}, (TIE != 0) ? 32'd2 : 32'd1);
  endtask

  task automatic test_clr();
    drive(1'b1, 1'b1, 1'b0, 2'd0, 2'd0, 32'd10, 16'd0, 16'd0, 16'd4);
    step();
    drive(1'b1, 1'b1, 1'b1, 2'd0, 2'd0, 32'd900, 16'd0, 16'd0, 16'd5);
    step(); idle(2'd0); step();
    chk("clr_acc_t", t, 32'd900);
    chk("clr_acc_any", {31'd0, anyhit}, 32'd1);
    drive(1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 32'd0, 16'd0, 16'd0, 16'd0);
    step(); idle(2'd0); step();
    chk("clr_any", {31'd0, anyhit}, 32'd0);
    chk("clr_retained_t", t, 32'd900);
    chk("clr_mask", {28'd0, held_mask}, 32'd6);
  endtask

  task automatic test_read_before_write();
    drive(1'b1, 1'b1, 1'b0, 2'd3, 2'd3, 32'd5, 16'd0, 16'd0, 16'd11);
    step();
    chk("rbw_first_any", {31'd0, anyhit}, 32'd0);
    idle(2'd3);
    step();
    chk("rbw_t", t, 32'd5);
    chk("rbw_any", {31'd0, anyhit}, 32'd1);
  endtask

  task automatic test_boundary();
    drive(1'b1, 1'b1, 1'b1, 2'd3, 2'd3, 32'hFFFF_FFFF, 16'd0, 16'd0, 16'd20);
    step(); idle(2'd3); step();
    chk("allones_t", t, 32'hFFFF_FFFF);
    drive(1'b1, 1'b1, 1'b0, 2'd3, 2'd3, 32'hFFFF_FFFE, 16'd0, 16'd0, 16'd21);
    step();
    drive(1'b1, 1'b0, 1'b0, 2'd3, 2'd3, 32'd0, 16'd0, 16'd0, 16'd22);
    step();
    drive(1'b0, 1'b1, 1'b0, 2'd3, 2'd3, 32'd0, 16'd0, 16'd0, 16'd23);
    step(); idle(2'd3); step();
    chk("below_ones_t", t, 32'hFFFF_FFFE);
    chk("nohit_id", {16'd0, triid}, 32'd21);
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) == 0),
            2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 32'($urandom_range(0, 20)),
            16'($urandom), 16'($urandom), 16'($urandom));
      step();
    end
  endtask

  task automatic test_async_reset();
    drive(1'b1, 1'b1, 1'b0, 2'd1, 2'd1, 32'd1, 16'd0, 16'd0, 16'd30);
    step();
    globalreset = 1'b1;
    #1;
    checks++;
    if ({t, u, v, triid, anyhit, held_mask} !== '0) begin
      errors++;
      $display("FAIL async_reset: got t=%0d id=%0d any=%0b mask=%b want all 0", t, triid, anyhit, held_mask);
    end
    @(posedge clk);
    #1;
    globalreset = 1'b0;
    model_reset();
    chk("reset_accept_dropped", {28'd0, held_mask}, 32'd0);
    drive(1'b1, 1'b1, 1'b0, 2'd1, 2'd1, 32'd77, 16'd0, 16'd0, 16'd31);
    step(); idle(2'd1); step();
    chk("post_reset_t", t, 32'd77);
  endtask

`ifdef NEARCMP_HITCNT_EN
  task automatic test_hitcnt();
    for (int n = 0; n < 300; n++) begin
      drive(1'b1, 1'b1, 1'b0, 2'd1, 2'd1, 32'(1000 - n), 16'd0, 16'd0, 16'd0);
      step();
    end
    idle(2'd1); step();
    chk("cnt_sat", {24'd0, hit_cnt}, 32'd255);
    drive(1'b1, 1'b1, 1'b1, 2'd1, 2'd1, 32'd3, 16'd0, 16'd0, 16'd0);
    step(); idle(2'd1); step();
    chk("cnt_clr_acc", {24'd0, hit_cnt}, 32'd1);
  endtask
`endif

  initial begin
    test_reset();
    test_first_accept();
    test_nearer();
    test_tie();
    test_clr();
    test_read_before_write();
    test_boundary();
    test_random();
`ifdef NEARCMP_HITCNT_EN
    test_hitcnt();
`endif
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
